// File: rtl/zs_pkg.sv
// Shared types and helpers for the zero-skip packer: pack-mode encoding and beat count width.
package zs_pkg;

  typedef enum logic [1:0] {
    ZS_K1   = 2'd0,
    ZS_K2   = 2'd1,
    ZS_K4   = 2'd2,
    ZS_KRSV = 2'd3
  } zs_mode_t;

  localparam int BEAT_CNT_W = 3;

  // Beats per pack; the reserved encoding behaves as K=4.
  function automatic logic [BEAT_CNT_W-1:0] zs_k(input zs_mode_t m);
    case (m)
      ZS_K1:   return BEAT_CNT_W'(1);
      ZS_K2:   return BEAT_CNT_W'(2);
      default: return BEAT_CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/zs_row_compact.sv
// Combinational per-row compactor: moves the masked nonzeros of one activation group into
// slots 0..cap-1 in ascending order, zero-fills the rest and flags any nonzero beyond cap.
module zs_row_compact
  import zs_pkg::*;
#(
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8,
  parameter int OUT_SLOTS  = 32
) (
  input  logic [GROUP_SIZE-1:0]         i_mask,
  input  logic [GROUP_SIZE*DATA_W-1:0]  i_act,
  input  logic [$clog2(OUT_SLOTS+1)-1:0] i_cap,
  output logic [OUT_SLOTS*DATA_W-1:0]   o_slots,
  output logic                          o_ovf
);

  always_comb begin
    int n;
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned
    // and no latch is inferred.
    o_slots = '0;
    o_ovf   = 1'b0;
    n       = 0;
    // NOTE: blocking assignments here, because each iteration must see the running count n.
    for (int j = 0; j < GROUP_SIZE; j++) begin
      if (i_mask[j]) begin
        if (n < int'(i_cap)) o_slots[n*DATA_W +: DATA_W] = i_act[j*DATA_W +: DATA_W];
        else                 o_ovf = 1'b1;
        n++;
      end
    end
  end

endmodule

// File: rtl/zs_pack_stream.sv
// Zero-skip packer: compacts each row's nonzeros per beat (S1) and packs K beats per row into
// one output word (S2). Optional macro ZS_PACK_OVF_STAT_EN adds the ovf_cnt_o beat counter.
module zs_pack_stream
  import zs_pkg::*;
#(
  parameter int M          = 32,
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8,
  parameter int OUT_SLOTS  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode_i,
  input  logic                          flush_i,
  input  logic [M*GROUP_SIZE-1:0]       znz_i,
  input  logic [GROUP_SIZE*DATA_W-1:0]  act_i,
  input  logic                          in_vld_i,
  output logic                          in_rdy_o,
  output logic [M*OUT_SLOTS*DATA_W-1:0] dout_o,
  output logic                          dout_vld_o,
  input  logic                          dout_rdy_i,
  output logic [2:0]                    dout_beats_o,
  output logic [M-1:0]                  ovf_o
`ifdef ZS_PACK_OVF_STAT_EN
  ,
  output logic [15:0]                   ovf_cnt_o
`endif
);

  localparam int ROW_W = OUT_SLOTS * DATA_W;
  localparam int CAP_W = $clog2(OUT_SLOTS + 1);

  // S1 stage
  logic                  r_s1_vld;
  logic [M*ROW_W-1:0]    r_s1_slice;
  logic [M-1:0]          r_s1_ovf;
  logic [CAP_W-1:0]      r_s1_off;
  logic [BEAT_CNT_W-1:0] r_s1_pos;
  logic                  r_s1_last;
  logic [BEAT_CNT_W-1:0] r_in_cnt;
  zs_mode_t              r_mode_q;

  // S2 stage (the accumulator is the output word)
  logic [M*ROW_W-1:0]    r_acc;
  logic [M-1:0]          r_ovf;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [BEAT_CNT_W-1:0] r_dout_beats;
  logic                  r_dout_vld;

  logic                  w_s1_adv;
  logic                  w_in_fire;
  logic                  w_flush;
  logic [BEAT_CNT_W-1:0] w_pos;
  zs_mode_t              w_mode;
  logic                  w_last;
  logic [CAP_W-1:0]      w_cap;
  logic [CAP_W-1:0]      w_off;
  logic [M*ROW_W-1:0]    w_slice;
  logic [M-1:0]          w_ovf;
  logic [M*ROW_W-1:0]    w_acc_nxt;

  assign w_s1_adv  = r_s1_vld & (~r_dout_vld | dout_rdy_i);
  assign in_rdy_o  = ~r_s1_vld | w_s1_adv;
  assign w_in_fire = in_vld_i & in_rdy_o;
  assign w_flush   = flush_i & ~r_s1_vld & (r_beat_cnt != '0) & ~r_dout_vld;

  // A flush in the same cycle as a capture closes the old pack, so the new beat is beat 0.
  assign w_pos  = w_flush ? '0 : r_in_cnt;
  assign w_mode = (w_pos == '0) ? zs_mode_t'(mode_i) : r_mode_q;
  assign w_last = ((w_pos + BEAT_CNT_W'(1)) == zs_k(w_mode));
  assign w_off  = CAP_W'(w_pos) * w_cap;

  always_comb begin
    case (w_mode)
      ZS_K1:   w_cap = CAP_W'(OUT_SLOTS);
      ZS_K2:   w_cap = CAP_W'(OUT_SLOTS / 2);
      default: w_cap = CAP_W'(OUT_SLOTS / 4);
    endcase
  end

  for (genvar r = 0; r < M; r++) begin : g_row
    zs_row_compact #(
      .GROUP_SIZE (GROUP_SIZE),
      .DATA_W     (DATA_W),
      .OUT_SLOTS  (OUT_SLOTS)
    ) u_row (
      .i_mask  (znz_i[r*GROUP_SIZE +: GROUP_SIZE]),
      .i_act   (act_i),
      .i_cap   (w_cap),
      .o_slots (w_slice[r*ROW_W +: ROW_W]),
      .o_ovf   (w_ovf[r])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_in_cnt <= '0;
      r_mode_q <= ZS_K1;
    end else begin
      if (w_in_fire)     r_s1_vld <= 1'b1;
      else if (w_s1_adv) r_s1_vld <= 1'b0;

      if (w_in_fire) begin
        r_in_cnt <= w_last ? '0 : w_pos + BEAT_CNT_W'(1);
        if (w_pos == '0) r_mode_q <= w_mode;
      end else if (w_flush) begin
        r_in_cnt <= '0;
      end
    end
  end

  // NOTE: the S1 payload has no reset; it is only consumed while r_s1_vld is set, whereas the
  // accumulator is reset because it drives dout_o directly.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_slice <= w_slice;
      r_s1_ovf   <= w_ovf;
      r_s1_off   <= w_off;
      r_s1_pos   <= w_pos;
      r_s1_last  <= w_last;
    end
  end

  // Beat 0 clears the row before merging, so each pack starts at slot 0 with zero padding.
  always_comb begin
    w_acc_nxt = '0;
    for (int r = 0; r < M; r++) begin
      w_acc_nxt[r*ROW_W +: ROW_W] =
        ((r_s1_pos == '0) ? '0 : r_acc[r*ROW_W +: ROW_W]) |
        (r_s1_slice[r*ROW_W +: ROW_W] << (int'(r_s1_off) * DATA_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_ovf        <= '0;
      r_beat_cnt   <= '0;
      r_dout_beats <= '0;
      r_dout_vld   <= 1'b0;
    end else if (w_s1_adv) begin
      r_acc <= w_acc_nxt;
      r_ovf <= ((r_s1_pos == '0) ? '0 : r_ovf) | r_s1_ovf;
      if (r_s1_last) begin
        r_beat_cnt   <= '0;
        r_dout_beats <= r_s1_pos + BEAT_CNT_W'(1);
        r_dout_vld   <= 1'b1;
      end else begin
        r_beat_cnt   <= r_s1_pos + BEAT_CNT_W'(1);
        r_dout_vld   <= 1'b0;
      end
    end else if (w_flush) begin
      r_dout_beats <= r_beat_cnt;
      r_beat_cnt   <= '0;
      r_dout_vld   <= 1'b1;
    end else if (dout_rdy_i) begin
      r_dout_vld <= 1'b0;
    end
  end

  assign dout_o       = r_acc;
  assign dout_vld_o   = r_dout_vld;
  assign dout_beats_o = r_dout_beats;
  assign ovf_o        = r_ovf;

`ifdef ZS_PACK_OVF_STAT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_ovf_cnt <= '0;
    else if (w_in_fire && (|w_ovf) && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign ovf_cnt_o = r_ovf_cnt;
`endif

endmodule
